// File: rtl/prog_loader.sv
// Program-memory loader: accepts a stream of instruction words, writes them
// into program ROM, zero-fills the unused tail, holds the processor in reset
// for a fixed settle time, then releases it with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | after reset; processor held in reset, waiting for load_start
//   LOAD  | accepting words, one ROM write per accepted word
//   FILL  | writing zeros from the word after the last one up to the top address
//   HOLD  | last write done; processor kept in reset for HOLD_CYCLES cycles
//   RUN   | processor released; a new load_start restarts a session
module prog_loader #(
  parameter int PROG_SIZE   = 1024,
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 18,
  parameter int HOLD_CYCLES = 4     // must be >= 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   word_valid,
  input  logic [INSTR_WIDTH-1:0] word_data,
  input  logic                   word_last,
  output logic                   word_ready,
  output logic                   rom_we,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic [INSTR_WIDTH-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   overflow_err
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_t;

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_SIZE - 1);
  localparam logic [HCW-1:0]        HOLD_INIT = HCW'(HOLD_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [HCW-1:0]        hold_cnt;
  logic                  xfer;

  // A word moves only while loading and the registered ready is up.
  assign xfer = (state == LOAD) && word_valid && word_ready;

  // Sequencer: state, write pointer, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      word_ready   <= 1'b0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            state        <= LOAD;
            ptr          <= '0;
            load_count   <= '0;
            overflow_err <= 1'b0;
            word_ready   <= 1'b1;
            cpu_reset    <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            rom_we     <= 1'b1;
            rom_addr   <= ptr;
            rom_wdata  <= word_data;
            load_count <= load_count + 1'b1;
            if (ptr == LAST_ADDR) begin
              // Memory is full: stop here whether or not the word was last.
              state        <= HOLD;
              word_ready   <= 1'b0;
              hold_cnt     <= HOLD_INIT;
              overflow_err <= ~word_last;
            end else begin
              ptr <= ptr + 1'b1;
              if (word_last) begin
                state      <= FILL;
                word_ready <= 1'b0;
              end
            end
          end
        end
        FILL: begin
          rom_we    <= 1'b1;
          rom_addr  <= ptr;
          rom_wdata <= '0;
          if (ptr == LAST_ADDR) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        HOLD: begin
          // The final write is visible in the first HOLD cycle, so the
          // release lands HOLD_CYCLES cycles after it.
          if (hold_cnt == '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load with fill, full load, overflow,
// throttled input, reset mid-session and reload from RUN.
module tb_prog_loader;

  localparam int AW = 10;
  localparam int IW = 18;

  logic          clk = 1'b0;
  logic          reset, load_start, word_valid, word_last;
  logic [IW-1:0] word_data;
  logic          word_ready, rom_we, cpu_reset, load_done, overflow_err;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_wdata;
  logic [AW:0]   load_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  wr_t           log_q[$];
  logic [IW-1:0] mem[1024];
  int            last_we_cyc = 0;

  prog_loader #(.PROG_SIZE(1024), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_count(load_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture every ROM write away from the clock edge.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      log_q.push_back('{rom_addr, rom_wdata});
      mem[rom_addr] = rom_wdata;
      last_we_cyc   = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    for (int i = 0; i < 1024; i++) mem[i] = 18'h15555;
  endtask

  // Waits for load_done (bounded), checking the processor stays in reset
  // until then and that release lands 4 cycles after the final write.
  task automatic wait_done(input string tag);
    int   n;
    logic early;
    n     = 0;
    early = 1'b0;
    while (load_done !== 1'b1 && n < 3000) begin
      if (cpu_reset !== 1'b1) early = 1'b1;
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(load_done), 32'd1);
    chk({tag, "_rst_held"}, 32'(early), 32'd0);
    chk({tag, "_cpu_rel"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_done_lat"}, 32'(cyc - last_we_cyc), 32'd4);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    int nz;
    reset = 1'b1; load_start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = '0;
    clear_log();
    step(); step();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Three words back to back, then zero fill.
    clear_log();
    start_load();
    chk("a_ready", 32'(word_ready), 32'd1);
    word_valid = 1'b1; word_data = 18'h00001; word_last = 1'b0; step();
    chk("a_we0", 32'(rom_we), 32'd1);
    chk("a_addr0", 32'(rom_addr), 32'd0);
    chk("a_data0", 32'(rom_wdata), 32'h00001);
    word_data = 18'h00002; step();
    word_data = 18'h3FFFF; word_last = 1'b1; step();
    chk("a_ready_drop", 32'(word_ready), 32'd0);
    word_valid = 1'b0; word_last = 1'b0; word_data = 18'h12345;
    wait_done("a");
    chk("a_writes", 32'(log_q.size()), 32'd1024);
    chk("a_mem1", 32'(mem[1]), 32'h00002);
    chk("a_mem2", 32'(mem[2]), 32'h3FFFF);
    nz = 0;
    for (int i = 3; i < 1024; i++) if (mem[i] !== 18'h0) nz++;
    chk("a_fill_zero", 32'(nz), 32'd0);
    chk("a_count", 32'(load_count), 32'd3);
    chk("a_overflow", 32'(overflow_err), 32'd0);
    step();
    chk("a_done_pulse", 32'(load_done), 32'd0);
    chk("a_run_cpu", 32'(cpu_reset), 32'd0);

    // 1025 words, none last: overflow at the top address.
    clear_log();
    start_load();
    chk("c_run_restart", 32'(cpu_reset), 32'd1);
    word_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      word_data = 18'(i + 18'h100);
      step();
    end
    chk("c_ready_drop", 32'(word_ready), 32'd0);
    chk("c_overflow", 32'(overflow_err), 32'd1);
    chk("c_count", 32'(load_count), 32'd1024);
    word_data = 18'h2AAAA;
    wait_done("c");
    word_valid = 1'b0;
    chk("c_writes", 32'(log_q.size()), 32'd1024);
    chk("c_mem_top", 32'(mem[1023]), 32'(18'(1023 + 18'h100)));
    chk("c_ovf_sticky", 32'(overflow_err), 32'd1);

    // Reload from RUN: overflow cleared, exact 1024-word program.
    clear_log();
    start_load();
    chk("b_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("b_ovf_clear", 32'(overflow_err), 32'd0);
    chk("b_count_clear", 32'(load_count), 32'd0);
    word_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      word_data = 18'(i * 7 + 3);
      word_last = (i == 1023);
      step();
    end
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("b");
    chk("b_writes", 32'(log_q.size()), 32'd1024);
    chk("b_mem0", 32'(mem[0]), 32'd3);
    chk("b_mem_top", 32'(mem[1023]), 32'(18'(1023 * 7 + 3)));
    chk("b_overflow", 32'(overflow_err), 32'd0);
    chk("b_count", 32'(load_count), 32'd1024);

    // Valid toggling every cycle, junk data while invalid.
    clear_log();
    start_load();
    for (int i = 0; i < 10; i++) begin
      word_valid = (i % 2 == 0);
      word_data  = word_valid ? 18'(18'h100 + i / 2) : 18'h3ABCD;
      word_last  = (i == 8);
      step();
    end
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("d");
    chk("d_writes", 32'(log_q.size()), 32'd1024);
    for (int k = 0; k < 5; k++) begin
      chk("d_addr", 32'(log_q[k].a), 32'(k));
      chk("d_data", 32'(log_q[k].d), 32'(18'h100 + k));
    end
    chk("d_fill_addr", 32'(log_q[5].a), 32'd5);
    chk("d_count", 32'(load_count), 32'd5);

    // Reset after ten accepted words aborts the session.
    clear_log();
    start_load();
    word_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      word_data = 18'(i + 18'h200);
      step();
    end
    word_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("e_we_off", 32'(rom_we), 32'd0);
    chk("e_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("e_count", 32'(load_count), 32'd0);
    chk("e_ready", 32'(word_ready), 32'd0);
    clear_log();
    for (int i = 0; i < 5; i++) step();
    chk("e_no_writes", 32'(log_q.size()), 32'd0);
    chk("e_idle_cpu", 32'(cpu_reset), 32'd1);
    start_load();
    word_valid = 1'b1; word_data = 18'h0ABCD; word_last = 1'b0; step();
    word_data = 18'h0BEEF; word_last = 1'b1; step();
    word_valid = 1'b0; word_last = 1'b0;
    wait_done("e");
    chk("e_writes", 32'(log_q.size()), 32'd1024);
    chk("e_addr0", 32'(log_q[0].a), 32'd0);
    chk("e_data0", 32'(log_q[0].d), 32'h0ABCD);
    chk("e_addr1", 32'(log_q[1].a), 32'd1);
    chk("e_data1", 32'(log_q[1].d), 32'h0BEEF);
    chk("e_count2", 32'(load_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter PROG_SIZE, 1024, number of program memory words.
REQ-002 Parameter ADDR_WIDTH, 10, program memory address width.
REQ-003 Parameter INSTR_WIDTH, 18, instruction word width.
REQ-004 Parameter HOLD_CYCLES, 4, cycles processor reset is held after the last memory write.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  reset is synchronous and active-high.
REQ-007 load_start  input  1  one-cycle request to begin a load session.
REQ-008 word_valid  input  1  word_data/word_last valid.
REQ-009 word_data  input  INSTR_WIDTH  instruction word.
REQ-010 word_last  input  1  marks final word of program.
REQ-011 word_ready  output  1  loader accepts a word this cycle.
REQ-012 rom_we  output  1  program memory write enable.
REQ-013 rom_addr  output  ADDR_WIDTH  program memory write address.
REQ-014 rom_wdata  output  INSTR_WIDTH  program memory write data.
REQ-015 cpu_reset  output  1  drives processor reset port.
REQ-016 load_done  output  1  one-cycle pulse when processor is released.
REQ-017 load_count  output  ADDR_WIDTH+1  words accepted in current/last session (fill excluded).
REQ-018 overflow_err  output  1  sticky; program exceeded PROG_SIZE without word_last.

Function
REQ-019 States SHALL be IDLE, LOAD, FILL, HOLD, RUN.
REQ-020 IDLE: cpu_reset=1, word_ready=0; load_start -> LOAD.
REQ-021 Entering LOAD SHALL clear write pointer, load_count and overflow_err.
REQ-022 LOAD: word_ready=1 (registered, asserted the cycle after entry); transfer occurs iff word_valid && word_ready.
REQ-023 Each transfer SHALL produce, the following cycle, rom_we=1, rom_addr=pointer, rom_wdata=word_data; pointer and load_count increment by 1.
REQ-024 word_valid without word_ready SHALL cause no write; word_data may change freely while word_valid=0.
REQ-025 Transfer with word_last=1 at pointer < PROG_SIZE-1 -> FILL; word_ready deasserts the next cycle.
REQ-026 Transfer at pointer = PROG_SIZE-1 -> HOLD regardless of word_last; if word_last=0, overflow_err=1.
REQ-027 After the session ends, no further words accepted; pointer SHALL never wrap to 0 within a session.
REQ-028 FILL: one write per cycle, rom_wdata=0, addresses from last-word-address+1 to PROG_SIZE-1 inclusive, then HOLD.
REQ-029 HOLD: cpu_reset=1 for HOLD_CYCLES cycles counted after the final rom_we cycle; then load_done=1 for exactly one cycle and state RUN.
REQ-030 RUN: cpu_reset=0, rom_we=0, word_ready=0; load_start -> LOAD with cpu_reset=1 from the next cycle.
REQ-031 load_start SHALL be ignored in LOAD, FILL, HOLD.
REQ-032 rom_we SHALL never be asserted outside LOAD-transfer follow-up and FILL.
REQ-033 load_count and overflow_err SHALL hold their values in HOLD, RUN and IDLE until next LOAD entry.

Reset
REQ-034 reset=1 SHALL, at next clock edge, force IDLE, cpu_reset=1, word_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, load_done=0, load_count=0, overflow_err=0.
REQ-035 reset mid-LOAD/FILL/HOLD SHALL abort the session with no further writes; processor stays in reset until a new session completes.

Verification
REQ-036 load_start, 3 words (0x00001,0x00002,0x3FFFF last) back-to-back -> writes addr 0..2 with those data, zero writes addr 3..1023, load_count=3, load_done 4 cycles after addr-1023 write, cpu_reset falls with load_done.
REQ-037 1024 words, last on word 1023 -> no FILL writes, overflow_err=0, load_count=1024.
REQ-038 1025 words, none flagged last -> 1024 writes, word_ready low after addr 1023, overflow_err=1, word 1025 never written.
REQ-039 word_valid toggled 1/0 every cycle with 5 words -> exactly 5 writes, addresses contiguous 0..4, data in order.
REQ-040 reset asserted after 10 words accepted -> rom_we=0 next cycle, cpu_reset=1, load_count=0; new load_start then 2 words restarts at addr 0.
REQ-041 load_start in RUN -> cpu_reset=1 next cycle, overflow_err cleared, new program written from addr 0.
